// File: rtl/spectral_peak_detector.sv
// -----------------------------------------------------------------------------
// spectral_peak_detector
//
// Consumes a per-bin power stream (one FFT frame = FFT_SIZE samples, bin 0
// first) and, over the inclusive bin window BIN_LO..BIN_HI, reports the peak
// bin index, the peak power and the total window energy once per frame.
//
// Ports:
//   clk_in            system clock
//   rst_in            asynchronous active-high reset
//   power_data_in     unsigned 32-bit bin power
//   power_valid_in    power_data_in is valid
//   power_ready_out   a sample is accepted this cycle when valid is also high
//   result_ready_in   consumer takes the pending result
//   result_valid_out  result registers hold an unconsumed result
//   peak_bin_out      index of the maximum bin in the window (lowest on ties)
//   peak_power_out    power at peak_bin_out
//   energy_out        sum of power over the window
// -----------------------------------------------------------------------------
module spectral_peak_detector #(
    parameter int FFT_SIZE = 1024,
    parameter int BIN_LO   = 1,
    parameter int BIN_HI   = 511,
    localparam int BW      = $clog2(FFT_SIZE),
    localparam int EW      = 32 + BW
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [31:0]   power_data_in,
    input  logic          power_valid_in,
    output logic          power_ready_out,
    input  logic          result_ready_in,
    output logic          result_valid_out,
    output logic [BW-1:0] peak_bin_out,
    output logic [31:0]   peak_power_out,
    output logic [EW-1:0] energy_out
);

    // Frame position and running (per-frame) accumulators
    logic [BW-1:0] r_bin_cnt;
    logic [31:0]   r_run_peak;
    logic [BW-1:0] r_run_idx;
    logic [EW-1:0] r_run_energy;

    // Result registers
    logic          r_res_valid;
    logic [BW-1:0] r_res_bin;
    logic [31:0]   r_res_peak;
    logic [EW-1:0] r_res_energy;

    logic          w_accept;
    logic          w_last;
    logic          w_in_win;
    logic          w_take;
    int            w_bin_int;
    logic [31:0]   w_peak_nx;
    logic [BW-1:0] w_idx_nx;
    logic [EW-1:0] w_energy_nx;

    // Signed view of the bin counter so window bounds of 0 or FFT_SIZE-1
    // do not turn into constant unsigned comparisons.
    assign w_bin_int = int'(r_bin_cnt);

    assign w_last   = (r_bin_cnt == BW'(FFT_SIZE - 1));
    // Ready depends only on registered state: stall the final bin of a frame
    // while the previous result is still waiting, so no result is overwritten.
    assign power_ready_out = !(r_res_valid && w_last);
    assign w_accept = power_valid_in && power_ready_out;

    assign w_in_win = (w_bin_int >= BIN_LO) && (w_bin_int <= BIN_HI);
    // The first window bin always seeds the peak; afterwards only a strictly
    // larger sample replaces it, which keeps the lowest index on ties.
    assign w_take   = w_in_win && ((w_bin_int == BIN_LO) || (power_data_in > r_run_peak));

    assign w_peak_nx   = w_take ? power_data_in : r_run_peak;
    assign w_idx_nx    = w_take ? r_bin_cnt     : r_run_idx;
    assign w_energy_nx = w_in_win ? (r_run_energy + EW'(power_data_in)) : r_run_energy;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_bin_cnt    <= '0;
            r_run_peak   <= '0;
            r_run_idx    <= '0;
            r_run_energy <= '0;
            r_res_valid  <= 1'b0;
            r_res_bin    <= '0;
            r_res_peak   <= '0;
            r_res_energy <= '0;
        end else begin
            if (r_res_valid && result_ready_in) begin
                r_res_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_last) begin
                    // Frame end: publish (this overrides the clear above when
                    // a consume and a load land on the same edge) and restart.
                    r_bin_cnt    <= '0;
                    r_res_valid  <= 1'b1;
                    r_res_bin    <= w_idx_nx;
                    r_res_peak   <= w_peak_nx;
                    r_res_energy <= w_energy_nx;
                    r_run_peak   <= '0;
                    r_run_idx    <= '0;
                    r_run_energy <= '0;
                end else begin
                    r_bin_cnt    <= r_bin_cnt + BW'(1);
                    r_run_peak   <= w_peak_nx;
                    r_run_idx    <= w_idx_nx;
                    r_run_energy <= w_energy_nx;
                end
            end
        end
    end

    assign result_valid_out = r_res_valid;
    assign peak_bin_out     = r_res_bin;
    assign peak_power_out   = r_res_peak;
    assign energy_out       = r_res_energy;

endmodule

// File: tb/tb_spectral_peak_detector.sv
module tb_spectral_peak_detector;

    localparam int N      = 16;
    localparam int LO     = 1;
    localparam int HI     = 8;
    localparam int MAXN   = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] power_data_in;
    logic        power_valid_in;
    logic        power_ready_out;
    logic        result_ready_in;
    logic        result_valid_out;
    logic [3:0]  peak_bin_out;
    logic [31:0] peak_power_out;
    logic [35:0] energy_out;

    logic [31:0] mx_data;
    logic        mx_valid;
    logic        mx_ready;
    logic        mx_rr;
    logic        mx_res_valid;
    logic [9:0]  mx_bin;
    logic [31:0] mx_peak;
    logic [41:0] mx_energy;

    always #5 clk = ~clk;

    spectral_peak_detector #(.FFT_SIZE(N), .BIN_LO(LO), .BIN_HI(HI)) dut (
        .clk_in(clk), .rst_in(rst),
        .power_data_in(power_data_in), .power_valid_in(power_valid_in),
        .power_ready_out(power_ready_out), .result_ready_in(result_ready_in),
        .result_valid_out(result_valid_out), .peak_bin_out(peak_bin_out),
        .peak_power_out(peak_power_out), .energy_out(energy_out)
    );

    spectral_peak_detector dut_max (
        .clk_in(clk), .rst_in(rst),
        .power_data_in(mx_data), .power_valid_in(mx_valid),
        .power_ready_out(mx_ready), .result_ready_in(mx_rr),
        .result_valid_out(mx_res_valid), .peak_bin_out(mx_bin),
        .peak_power_out(mx_peak), .energy_out(mx_energy)
    );

    typedef struct {
        int          bin;
        logic [31:0] pw;
        logic [63:0] en;
    } res_t;

    res_t        exp_q[$];
    logic [31:0] cur_frame[N];
    int          m_cnt;
    logic [31:0] frame_buf[N];

    int          n_tests;
    int          n_fail;

    logic [63:0] dut_last_bin, dut_last_pw, dut_last_en;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: max over the window, then the first bin holding it; plain sum.
    function automatic res_t model_frame();
        res_t r;
        logic [31:0] mx;
        mx   = 0;
        r.en = 0;
        for (int k = LO; k <= HI; k++) begin
            if (cur_frame[k] > mx) mx = cur_frame[k];
            r.en += 64'(cur_frame[k]);
        end
        r.pw  = mx;
        r.bin = -1;
        for (int k = LO; k <= HI; k++)
            if (r.bin < 0 && cur_frame[k] == mx) r.bin = k;
        return r;
    endfunction

    // One clock cycle: drive, sample at negedge, update the model, advance.
    task automatic step(input logic v, input logic [31:0] d, input logic rr, output logic acc);
        logic exp_rdy;
        power_valid_in  = v;
        power_data_in   = d;
        result_ready_in = rr;
        @(negedge clk);
        exp_rdy = !(exp_q.size() != 0 && m_cnt == N - 1);
        check_val("ready", power_ready_out, exp_rdy);
        check_val("res_valid", result_valid_out, exp_q.size() != 0);
        if (result_valid_out && exp_q.size() != 0) begin
            check_val("peak_bin", peak_bin_out, exp_q[0].bin);
            check_val("peak_power", peak_power_out, exp_q[0].pw);
            check_val("energy", energy_out, exp_q[0].en);
        end
        if (rr && result_valid_out) begin
            dut_last_bin = 64'(peak_bin_out);
            dut_last_pw  = 64'(peak_power_out);
            dut_last_en  = 64'(energy_out);
        end
        acc = v && exp_rdy;
        if (rr && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) begin
            cur_frame[m_cnt] = d;
            m_cnt++;
            if (m_cnt == N) begin
                exp_q.push_back(model_frame());
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // gap_mode: 0 none, 1 alternate, 2 random; rr_mode: 0 high, 1 low, 2 random
    task automatic send_frame(input int gap_mode, input int rr_mode);
        logic acc, v, rr, alt;
        int   guard;
        alt = 1'b0;
        for (int k = 0; k < N; k++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 500) begin
                case (gap_mode)
                    0:       v = 1'b1;
                    1:       begin v = alt; alt = !alt; end
                    default: v = 1'($urandom_range(0, 1));
                endcase
                case (rr_mode)
                    0:       rr = 1'b1;
                    1:       rr = 1'b0;
                    default: rr = 1'($urandom_range(0, 1));
                endcase
                step(v, frame_buf[k], rr, acc);
                guard++;
            end
            if (!acc) begin
                check_val("accept_timeout", guard, 0);
                return;
            end
        end
    endtask

    task automatic drain();
        logic acc;
        int   guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1'b0, 32'd0, 1'b1, acc);
            guard++;
        end
        check_val("drain_timeout", exp_q.size(), 0);
        step(1'b0, 32'd0, 1'b1, acc);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < N; k++) frame_buf[k] = 32'(100 * k);
    endtask

    task automatic check_last(input string tag, input int b, input int p, input int e);
        check_val({tag, "_bin"}, dut_last_bin, 64'(b));
        check_val({tag, "_pw"}, dut_last_pw, 64'(p));
        check_val({tag, "_en"}, dut_last_en, 64'(e));
    endtask

    initial begin
        logic acc;
        int   n;
        n_tests = 0;
        n_fail  = 0;
        m_cnt   = 0;
        rst = 1'b1;
        power_valid_in = 1'b0; power_data_in = '0; result_ready_in = 1'b0;
        mx_valid = 1'b0; mx_data = '0; mx_rr = 1'b0;
        #2;
        check_val("rst_valid", result_valid_out, 0);
        check_val("rst_bin", peak_bin_out, 0);
        check_val("rst_pw", peak_power_out, 0);
        check_val("rst_en", energy_out, 0);
        check_val("rst_ready", power_ready_out, 1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Basic ramp, back to back, consumer always ready
        load_ramp();
        send_frame(0, 0);
        drain();
        check_last("ramp", 8, 800, 3600);
        $display("[TB] basic ramp: bin=%0d pw=%0d en=%0d", dut_last_bin, dut_last_pw, dut_last_en);

        // Out-of-window large values, tie at the lowest index
        for (int k = 0; k < N; k++) frame_buf[k] = 0;
        frame_buf[0] = 1000000; frame_buf[12] = 999999; frame_buf[3] = 5; frame_buf[6] = 5;
        send_frame(0, 0);
        drain();
        check_last("window", 3, 5, 10);
        $display("[TB] window/tie: bin=%0d pw=%0d en=%0d", dut_last_bin, dut_last_pw, dut_last_en);

        // All-zero window
        for (int k = 0; k < N; k++) frame_buf[k] = 0;
        send_frame(0, 0);
        drain();
        check_last("zero", 1, 0, 0);
        $display("[TB] all-zero: bin=%0d pw=%0d en=%0d", dut_last_bin, dut_last_pw, dut_last_en);

        // Valid every other cycle
        load_ramp();
        send_frame(1, 0);
        drain();
        check_last("gaps", 8, 800, 3600);
        $display("[TB] valid gaps: bin=%0d pw=%0d en=%0d", dut_last_bin, dut_last_pw, dut_last_en);

        // Backpressure: two frames with the consumer stalled
        load_ramp();
        send_frame(0, 1);
        for (int k = 0; k < N - 1; k++) begin
            step(1'b1, frame_buf[k], 1'b0, acc);
            check_val("bp_accept", acc, 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, frame_buf[N-1], 1'b0, acc);
            check_val("bp_ready_low", power_ready_out, 0);
        end
        step(1'b1, frame_buf[N-1], 1'b1, acc);
        check_last("bp_first", 8, 800, 3600);
        step(1'b1, frame_buf[N-1], 1'b0, acc);
        check_val("bp_last_accept", acc, 1);
        step(1'b0, 32'd0, 1'b0, acc);
        check_val("bp_second_valid", result_valid_out, 1);
        drain();
        check_last("bp_second", 8, 800, 3600);
        $display("[TB] backpressure: bin=%0d pw=%0d en=%0d", dut_last_bin, dut_last_pw, dut_last_en);

        // Randomized frames, gaps and consumer stalls
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < N; k++)
                frame_buf[k] = (f % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            send_frame(2, 2);
            $display("[TB] random frame %0d sent, pending=%0d", f, exp_q.size());
        end
        drain();

        // Reset in the middle of a frame
        load_ramp();
        for (int k = 0; k < 5; k++) step(1'b1, frame_buf[k], 1'b1, acc);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_valid", result_valid_out, 0);
        check_val("mid_rst_bin", peak_bin_out, 0);
        check_val("mid_rst_pw", peak_power_out, 0);
        check_val("mid_rst_en", energy_out, 0);
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk); #1 rst = 1'b0;
        send_frame(0, 0);
        drain();
        check_last("post_rst", 8, 800, 3600);
        $display("[TB] reset mid-frame: bin=%0d pw=%0d en=%0d", dut_last_bin, dut_last_pw, dut_last_en);

        // Maximum values on the full-size default instance
        power_valid_in = 1'b0;
        mx_valid = 1'b1; mx_data = 32'hFFFF_FFFF; mx_rr = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (mx_ready) n++;
            if (n == MAXN) begin
                @(posedge clk); #1 mx_valid = 1'b0;
                break;
            end
        end
        check_val("max_accepts", n, MAXN);
        @(negedge clk);
        check_val("max_valid", mx_res_valid, 1);
        check_val("max_bin", mx_bin, 1);
        check_val("max_pw", mx_peak, 64'hFFFF_FFFF);
        check_val("max_en", mx_energy, 64'd511 * 64'hFFFF_FFFF);
        $display("[TB] max values: bin=%0d pw=%0h en=%0h", mx_bin, mx_peak, mx_energy);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
